// File: rtl/instr_receive_pkg.sv
// ============================================================================
// Module   : instr_receive_pkg
// Purpose  : Shared definitions for the instruction-transfer receiver.
//            Carries the instruction word width (`IWIDTH) and the receiver
//            state encoding used by instr_receive.
// Ports    : none (package)
// Config   : RECV_CHECKSUM_EN (consumed by instr_receive / instr_receive_if)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IWIDTH
`define IWIDTH 32
`endif

package instr_receive_pkg;

  // Instruction word width, mirrored from the shared `IWIDTH define.
  localparam int IW = `IWIDTH;

  // Receiver state encoding (3 bits).
  typedef enum logic [2:0] {
    RX_IDLE = 3'd0,
    RX_REQ  = 3'd1,
    RX_RECV = 3'd2,
    RX_DONE = 3'd3,
    RX_ERR  = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_receive_if.sv
// ============================================================================
// Module   : instr_receive_if
// Purpose  : Bundles the transfer handshake, the fetch read port and the
//            status outputs of the instruction receiver.
// Ports    : r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_addr  (to receiver)
//            r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done,
//            r_o_err [, r_o_csum]                             (from receiver)
// Modports : master - the receiver itself
//            slave  - the environment (transmitter + fetch stage)
// Config   : RECV_CHECKSUM_EN adds r_o_csum
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_receive_if
  import instr_receive_pkg::*;
#(
  parameter int AWIDTH = 6
);

  logic              r_i_start;
  logic              r_o_syn;
  logic [IW-1:0]     r_i_instr;
  logic              r_i_ack;
  logic              r_i_last;
  logic [AWIDTH-1:0] r_i_addr;
  logic [IW-1:0]     r_o_rdata;
  logic [AWIDTH:0]   r_o_count;
  logic              r_o_busy;
  logic              r_o_done;
  logic              r_o_err;
`ifdef RECV_CHECKSUM_EN
  logic [IW-1:0]     r_o_csum;
`endif

  modport master (
`ifdef RECV_CHECKSUM_EN
    output r_o_csum,
`endif
    input  r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_addr,
    output r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done, r_o_err
  );

  modport slave (
`ifdef RECV_CHECKSUM_EN
    input  r_o_csum,
`endif
    output r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_addr,
    input  r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done, r_o_err
  );

endinterface

`default_nettype wire

// File: rtl/instr_receive_buf.sv
// ============================================================================
// Module   : instr_buf
// Purpose  : Local instruction buffer, DEPTH x IW words. One synchronous
//            write port and one registered read port (1-cycle latency).
//            A read of the address written in the same cycle returns the
//            previous contents. Storage is never cleared by reset; only the
//            read register is.
// Ports    : clk    in  clock
//            rst    in  synchronous reset, active-low (clears rdata only)
//            we     in  write enable
//            waddr  in  write address
//            wdata  in  write data
//            raddr  in  read address
//            rdata  out registered read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_buf
  import instr_receive_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [IW-1:0]     wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [IW-1:0]     rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of the pre-write contents gives read-old-data behaviour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_receive.sv
// ============================================================================
// Module   : instr_receive
// Purpose  : Receiving end of the instruction-transfer link. On start it
//            raises syn, stores every acknowledged word into instr_buf,
//            finishes on ack&last (done) or on overflow / ack timeout (err).
//            The buffer read port serves the fetch stage afterwards.
// Ports    : r_clk  in  clock, all logic on posedge
//            r_rst  in  synchronous reset, active-low
//            bus    instr_receive_if.master (handshake, read port, status)
// Params   : DEPTH   buffer depth in words (power of two, >= 2)
//            AWIDTH  log2(DEPTH)
//            TIMEOUT max idle cycles waiting for an ack (>= 2)
// Config   : RECV_CHECKSUM_EN - adds bus.r_o_csum, running XOR of all words
//            stored in the current transfer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_receive
  import instr_receive_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int AWIDTH  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic           r_clk,
  input  logic           r_rst,
  instr_receive_if.master bus
);

  localparam int CW = AWIDTH + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT - 1);

  rx_state_t     state;
  logic          syn;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic          active;
  logic          wr_en;
`ifdef RECV_CHECKSUM_EN
  logic [IW-1:0] csum;
`endif

  // Acks are only meaningful while a transfer is in flight.
  assign active = (state == RX_REQ) || (state == RX_RECV);
  assign wr_en  = active && bus.r_i_ack;

  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      state    <= RX_IDLE;
      syn      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      wait_cnt <= '0;
`ifdef RECV_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        RX_IDLE, RX_DONE, RX_ERR: begin
          // Start wins over a coincident ack: nothing is stored this cycle.
          if (bus.r_i_start) begin
            state    <= RX_REQ;
            syn      <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            wait_cnt <= '0;
`ifdef RECV_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        RX_REQ, RX_RECV: begin
          if (bus.r_i_ack) begin
            count    <= count + 1'b1;
            wait_cnt <= '0;
`ifdef RECV_CHECKSUM_EN
            csum     <= csum ^ bus.r_i_instr;
`endif
            if (bus.r_i_last) begin
              // Last word fits even in the final slot.
              state <= RX_DONE;
              syn   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (count == LAST_SLOT) begin
              // Buffer just filled without last: word kept, transfer failed.
              state <= RX_ERR;
              syn   <= 1'b0;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state <= RX_RECV;
            end
          end else if (wait_cnt == WAIT_MAX) begin
            state <= RX_ERR;
            syn   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state <= RX_IDLE;
          syn   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  instr_buf #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_buf (
    .clk   (r_clk),
    .rst   (r_rst),
    .we    (wr_en),
    .waddr (count[AWIDTH-1:0]),
    .wdata (bus.r_i_instr),
    .raddr (bus.r_i_addr),
    .rdata (bus.r_o_rdata)
  );

  assign bus.r_o_syn   = syn;
  assign bus.r_o_busy  = busy;
  assign bus.r_o_done  = done;
  assign bus.r_o_err   = err;
  assign bus.r_o_count = count;
`ifdef RECV_CHECKSUM_EN
  assign bus.r_o_csum  = csum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_receive.sv
// ============================================================================
// Module   : tb_instr_receive
// Purpose  : Self-checking bench for instr_receive (DEPTH=8, TIMEOUT=16).
//            Directed cycle table, hand-written corner sequences, and random
//            transfers checked against a transaction-level model.
// Config   : RECV_CHECKSUM_EN enables the checksum sequence
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_receive;
  import instr_receive_pkg::*;

  localparam int DEPTH   = 8;
  localparam int AWIDTH  = 3;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_receive_if #(.AWIDTH(AWIDTH)) bus();

  instr_receive #(
    .DEPTH   (DEPTH),
    .AWIDTH  (AWIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .r_clk (clk),
    .r_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Expected buffer contents for the words of the most recent transfer.
  logic [IW-1:0] mm [DEPTH];

  typedef struct {
    logic          start;
    logic          ack;
    logic          last;
    logic [IW-1:0] instr;
    logic          syn;
    int            cnt;
    logic          done;
    logic          err;
  } vec_t;

  vec_t tv [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic syn, input int cnt,
                        input logic done, input logic err);
    chk({tag, ".syn"},   64'(bus.r_o_syn),   64'(syn));
    chk({tag, ".busy"},  64'(bus.r_o_busy),  64'(syn));
    chk({tag, ".count"}, 64'(bus.r_o_count), 64'(cnt));
    chk({tag, ".done"},  64'(bus.r_o_done),  64'(done));
    chk({tag, ".err"},   64'(bus.r_o_err),   64'(err));
  endtask

  task automatic send(input logic [IW-1:0] w, input logic lst);
    bus.r_i_ack   = 1'b1;
    bus.r_i_instr = w;
    bus.r_i_last  = lst;
    tick();
    bus.r_i_ack   = 1'b0;
    bus.r_i_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.r_i_start = 1'b1;
    tick();
    bus.r_i_start = 1'b0;
  endtask

  task automatic readback(input string tag, input int n);
    for (int a = 0; a < n; a++) begin
      bus.r_i_addr = AWIDTH'(a);
      tick();
      chk($sformatf("%s.rd%0d", tag, a), 64'(bus.r_o_rdata), 64'(mm[a]));
    end
  endtask

  initial begin
    bus.r_i_start = 1'b0;
    bus.r_i_ack   = 1'b0;
    bus.r_i_last  = 1'b0;
    bus.r_i_instr = '0;
    bus.r_i_addr  = '0;

    // ---- 1: reset state ------------------------------------------------
    rst = 1'b0;
    tick();
    tick();
    chk_st("reset", 1'b0, 0, 1'b0, 1'b0);
    chk("reset.rdata", 64'(bus.r_o_rdata), 64'd0);
`ifdef RECV_CHECKSUM_EN
    chk("reset.csum", 64'(bus.r_o_csum), 64'd0);
`endif
    rst = 1'b1;
    tick();

    // ---- directed cycle table -----------------------------------------
    tv[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0BAD, 1'b1, 0, 1'b0, 1'b0}; // start+ack in IDLE
    tv[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A1, 1'b1, 1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_00A2, 1'b1, 1, 1'b0, 1'b0}; // last w/o ack
    tv[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_00A3, 1'b1, 1, 1'b0, 1'b0}; // start while busy
    tv[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A4, 1'b1, 2, 1'b0, 1'b0};
    tv[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_00A5, 1'b0, 3, 1'b1, 1'b0}; // last
    tv[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A6, 1'b0, 3, 1'b1, 1'b0}; // ack in DONE
    tv[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_00A7, 1'b1, 0, 1'b0, 1'b0}; // restart from DONE
    tv[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A8, 1'b1, 1, 1'b0, 1'b0};
    tv[9] = '{1'b0, 1'b1, 1'b1, 32'h0000_00A9, 1'b0, 2, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.r_i_start = tv[i].start;
      bus.r_i_ack   = tv[i].ack;
      bus.r_i_last  = tv[i].last;
      bus.r_i_instr = tv[i].instr;
      tick();
      chk_st($sformatf("tv%0d", i), tv[i].syn, tv[i].cnt, tv[i].done, tv[i].err);
    end
    bus.r_i_start = 1'b0;
    bus.r_i_ack   = 1'b0;
    bus.r_i_last  = 1'b0;
    mm[0] = 32'h0000_00A8;
    mm[1] = 32'h0000_00A9;
    readback("tv", 2);

    // ---- 2: seven-word transfer ---------------------------------------
    pulse_start();
    chk_st("t2.start", 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mm[i] = 32'h2008_0001 + IW'(i);
      send(mm[i], i == 6);
      if (i == 5) chk_st("t2.w6", 1'b1, 6, 1'b0, 1'b0);
    end
    chk_st("t2.end", 1'b0, 7, 1'b1, 1'b0);
    readback("t2", 7);

    // ---- 3: timeout with no ack ---------------------------------------
    pulse_start();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk_st("t3.pre", 1'b1, 0, 1'b0, 1'b0);
    tick();
    chk_st("t3.err", 1'b0, 0, 1'b0, 1'b1);

    // ---- 4: overflow ---------------------------------------------------
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = 32'h5000_0000 + IW'(i);
      send(mm[i], 1'b0);
    end
    chk_st("t4.ovf", 1'b0, DEPTH, 1'b0, 1'b1);
    send(32'hDEAD_BEEF, 1'b0);
    chk_st("t4.ninth", 1'b0, DEPTH, 1'b0, 1'b1);
    readback("t4", DEPTH);

    // ---- 5: reset mid-transfer, then clean reload --------------------
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      mm[i] = 32'h7700_0000 + IW'(i);
      send(mm[i], 1'b0);
    end
    rst = 1'b0;
    tick();
    chk_st("t5.rst", 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    pulse_start();
    chk_st("t5.restart", 1'b1, 0, 1'b0, 1'b0);
    bus.r_i_addr = '0;
    send(32'h8800_0000, 1'b0);
    chk("t5.rd_old", 64'(bus.r_o_rdata), 64'(mm[0]));
    tick();
    chk("t5.rd_new", 64'(bus.r_o_rdata), 64'h8800_0000);
    send(32'h8800_0001, 1'b1);
    chk_st("t5.done", 1'b0, 2, 1'b1, 1'b0);

`ifdef RECV_CHECKSUM_EN
    // ---- 6: checksum ---------------------------------------------------
    pulse_start();
    chk("t6.csum0", 64'(bus.r_o_csum), 64'd0);
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h4, 1'b1);
    chk("t6.csum", 64'(bus.r_o_csum), 64'h7);
    chk_st("t6.done", 1'b0, 3, 1'b1, 1'b0);
    pulse_start();
    chk("t6.csum_clr", 64'(bus.r_o_csum), 64'd0);
    for (int i = 0; i < TIMEOUT; i++) tick();
`endif

    // ---- random transfers vs transaction-level model ------------------
    for (int t = 0; t < 24; t++) begin
      int            n;
      bit            has_last;
      int            st;      // 0 pending, 1 done, 2 error
      int            cnt;
      int            gap;
      int            r;
      logic [IW-1:0] w;
      n        = $urandom_range(2, DEPTH + 1);
      has_last = ($urandom_range(0, 3) != 0);
      st       = 0;
      cnt      = 0;
      pulse_start();
      chk($sformatf("rnd%0d.syn", t), 64'(bus.r_o_syn), 64'd1);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        gap = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          bus.r_i_last  = 1'($urandom_range(0, 1));
          bus.r_i_instr = IW'($urandom);
          bus.r_i_start = (st == 0 && gap < TIMEOUT) ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
        bus.r_i_start = 1'b0;
        bus.r_i_last  = 1'b0;
        w = IW'($urandom);
        send(w, has_last && (i == n - 1));
        if (st == 0) begin
          if (gap >= TIMEOUT) begin
            st = 2;
          end else begin
            mm[cnt] = w;
            cnt++;
            if (has_last && i == n - 1) st = 1;
            else if (cnt == DEPTH) st = 2;
          end
        end
      end
      for (int g = 0; g < TIMEOUT + 1; g++) tick();
      if (st == 0) st = 2;
      chk_st($sformatf("rnd%0d", t), 1'b0, cnt, st == 1, st == 2);
      readback($sformatf("rnd%0d", t), cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
